fold_mem_scheduler: RTL and testbench

//  Shares one folded BW x MW memory bank among NREQ requesters, time-multiplexed.

---
 rtl/fold_mem_scheduler.sv | 99 +++++++++
 tb/tb_fold_mem_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fold_mem_scheduler.sv
// fold_mem_scheduler: round-robin sharing of one folded BW x MW bank; each job fills, increments, then drains it.
module fold_mem_scheduler #(
    parameter int BW = 8,
    parameter int MW = 16,
    parameter int NREQ = 3,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*BW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_last,
    output logic [NREQ-1:0]   done
);
    localparam int AW = $clog2(MW);
    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {IDLE, FILL, PROC, DRAIN} state_t;

    state_t         st, nxt;
    logic [AW-1:0]  addr;
    logic [IDW-1:0] owner, ptr, win;
    logic [CW-1:0]  cand;
    logic [BW-1:0]  data;
    logic [BW-1:0]  mem [MW];
    logic           last, fire;

    assign last      = addr == AW'(MW - 1);
    assign busy      = st != IDLE;
    assign out_valid = st == DRAIN;
    assign fire      = out_valid && out_ready;
    assign out_data  = out_valid ? mem[addr] : '0;
    assign out_id    = out_valid ? owner : '0;
    assign out_last  = out_valid && last;

    // scan downward so the candidate closest to ptr overwrites the others
    always_comb begin
        win  = ptr;
        cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + CW'(i);
            cand = (cand >= CW'(NREQ)) ? cand - CW'(NREQ) : cand;
            win  = req[cand[IDW-1:0]] ? cand[IDW-1:0] : win;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = |req ? FILL : IDLE;
            FILL:    nxt = last ? PROC : FILL;
            PROC:    nxt = last ? DRAIN : PROC;
            DRAIN:   nxt = (fire && last) ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        st <= rst ? IDLE : nxt;

    always_ff @(posedge clk) begin
        if (st == FILL)
            mem[addr] <= data;
        else if (st == PROC)
            mem[addr] <= mem[addr] + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            owner <= '0;
            ptr   <= '0;
            data  <= '0;
            gnt   <= '0;
            done  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (st == IDLE && |req) begin
                owner <= win;
                data  <= req_data[int'(win)*BW +: BW];
                gnt   <= NREQ'(1) << win;
                addr  <= '0;
            end else if (st == FILL || st == PROC || fire) begin
                addr <= last ? '0 : addr + AW'(1);
            end
            if (fire && last) begin
                done <= NREQ'(1) << owner;
                ptr  <= (int'(owner) == NREQ - 1) ? '0 : owner + IDW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fold_mem_scheduler.sv
// tb_fold_mem_scheduler: job-level reference model checked every cycle, plus directed literal checks.
module tb_fold_mem_scheduler;
    localparam int BW = 8;
    localparam int MW = 16;
    localparam int NREQ = 3;
    localparam int IDW = 2;

    logic              clk = 0;
    logic              rst = 1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*BW-1:0] req_data = '0;
    logic              out_ready = 1;
    logic [NREQ-1:0]   gnt, done;
    logic              busy, out_valid, out_last;
    logic [BW-1:0]     out_data;
    logic [IDW-1:0]    out_id;

    fold_mem_scheduler #(.BW(BW), .MW(MW), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, gnt_cnt = 0, done_cnt = 0;
    int gq[$], gcyc[$], dcyc[$];
    logic [BW-1:0] hs_q[$];
    int last_idx = -1, lat = -1;
    logic prev_valid = 0;
    bit rnd = 0;

    // reference model: a job is granted, shows nothing for 2*MW cycles, then yields MW words of data+1
    bit m_known = 0, m_act = 0, e_valid;
    int m_t = 0, m_k = 0, m_owner = 0, m_ptr = 0, m_w;
    logic [BW-1:0] m_data = '0;
    logic [NREQ-1:0] e_gnt = '0, e_done = '0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (m_known) begin
            e_valid = m_act && m_t >= 2*MW;
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(m_act));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_data", 32'(out_data), e_valid ? 32'(m_data) : 32'h0);
            chk("out_last", 32'(out_last), 32'(e_valid && m_k == MW - 1));
            if (e_valid) chk("out_id", 32'(out_id), 32'(m_owner));
        end
        if (gnt != 0) begin
            gnt_cnt++;
            gcyc.push_back(cyc);
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
        end
        if (done != 0) begin
            done_cnt++;
            dcyc.push_back(cyc);
        end
        if (out_valid === 1'b1 && !prev_valid && gcyc.size() > 0) lat = cyc - gcyc[$];
        prev_valid = out_valid === 1'b1;
        if (out_valid === 1'b1 && out_ready) begin
            if (out_last) last_idx = hs_q.size();
            hs_q.push_back(out_data);
        end
        if (rst) begin
            m_known = 1; m_act = 0; m_ptr = 0; e_gnt = '0; e_done = '0;
        end else if (m_known) begin
            e_gnt = '0; e_done = '0;
            if (!m_act) begin
                m_w = -1;
                for (int i = 0; i < NREQ; i++)
                    if (m_w < 0 && req[(m_ptr + i) % NREQ]) m_w = (m_ptr + i) % NREQ;
                if (m_w >= 0) begin
                    m_owner = m_w;
                    m_data  = req_data[m_w*BW +: BW] + 8'd1;
                    e_gnt   = NREQ'(1) << m_w;
                    m_act = 1; m_t = 0; m_k = 0;
                end
            end else if (m_t < 2*MW) begin
                m_t++;
            end else if (out_ready) begin
                m_k++;
                if (m_k == MW) begin
                    m_act  = 0;
                    e_done = NREQ'(1) << m_owner;
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cnt(bit on_done, int target, string n);
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if ((on_done ? done_cnt : gnt_cnt) >= target) break;
        end
        if (k == 300) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for count %0d", n, target);
        end
    endtask

    task automatic job(int id, logic [7:0] d);
        int g, dn;
        g = gnt_cnt; dn = done_cnt;
        hs_q.delete(); gq.delete(); last_idx = -1;
        req_data[id*BW +: BW] = d;
        req = NREQ'(1) << id;
        wait_cnt(0, g + 1, "job_gnt");
        req = '0;
        wait_cnt(1, dn + 1, "job_done");
    endtask

    task automatic check_words(string n, logic [7:0] w);
        chk({n, "_count"}, 32'(hs_q.size()), 32'd16);
        for (int i = 0; i < hs_q.size(); i++) chk({n, "_word"}, 32'(hs_q[i]), 32'(w));
        chk({n, "_last_idx"}, 32'(last_idx), 32'd15);
    endtask

    initial begin
        int g, dn;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // basic job from requester 0
        job(0, 8'h41);
        check_words("t1", 8'h42);
        chk("t1_latency", 32'(lat), 32'd32);
        chk("t1_gnt_count", 32'(gq.size()), 32'd1);
        chk("t1_owner", 32'(gq[0]), 32'd0);
        // increment wraps
        job(0, 8'hFF);
        check_words("t2", 8'h00);
        // round robin with all requesting, then 0 and 1
        rst = 1; tick(); rst = 0;
        hs_q.delete(); gq.delete();
        g = gnt_cnt; dn = done_cnt;
        req_data = {8'h07, 8'h06, 8'h05};
        req = 3'b111;
        wait_cnt(0, g + 3, "t3_gnt3");
        req = 3'b011;
        wait_cnt(0, g + 5, "t3_gnt5");
        req = '0;
        wait_cnt(1, dn + 5, "t3_done");
        chk("t3_jobs", 32'(gq.size()), 32'd5);
        chk("t3_ord0", 32'(gq[0]), 32'd0);
        chk("t3_ord1", 32'(gq[1]), 32'd1);
        chk("t3_ord2", 32'(gq[2]), 32'd2);
        chk("t3_ord3", 32'(gq[3]), 32'd0);
        chk("t3_ord4", 32'(gq[4]), 32'd1);
        chk("t3_words", 32'(hs_q.size()), 32'd80);
        chk("t3_first", 32'(hs_q[0]), 32'h06);
        chk("t3_final", 32'(hs_q[79]), 32'h07);
        // random backpressure
        rnd = 1;
        job(1, 8'h20);
        rnd = 0; out_ready = 1;
        check_words("t4", 8'h21);
        // reset during PROC abandons the job
        dn = done_cnt; g = gnt_cnt;
        req_data[0 +: BW] = 8'h55;
        req = 3'b001;
        wait_cnt(0, g + 1, "t5_gnt");
        req = '0;
        repeat (20) tick();
        rst = 1; tick(); rst = 0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        repeat (3) tick();
        chk("t5_no_done", 32'(done_cnt), 32'(dn));
        job(1, 8'h10);
        check_words("t5", 8'h11);
        chk("t5_owner", 32'(gq[0]), 32'd1);
        // request raised mid-job waits for done
        hs_q.delete(); gq.delete();
        g = gnt_cnt; dn = done_cnt;
        req_data = {8'h7E, 8'h00, 8'h30};
        req = 3'b001;
        wait_cnt(0, g + 1, "t6_gnt0");
        req = '0;
        repeat (5) tick();
        req = 3'b100;
        wait_cnt(0, g + 2, "t6_gnt2");
        req = '0;
        wait_cnt(1, dn + 2, "t6_done");
        chk("t6_jobs", 32'(gq.size()), 32'd2);
        chk("t6_ord1", 32'(gq[1]), 32'd2);
        chk("t6_gnt_after_done", 32'(gcyc[gcyc.size()-1]), 32'(dcyc[dcyc.size()-2] + 1));
        chk("t6_first", 32'(hs_q[0]), 32'h31);
        chk("t6_final", 32'(hs_q[31]), 32'h7F);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
